// File: rtl/apple1_display_port.sv
// Apple-1 PIA display front end: synchronises the character bus and DA strobe, queues characters,
// drives RDA back-pressure and debounces the clear button. Optional macro: LOWERCASE_FOLD_EN.
module apple1_display_port #(
  parameter int DATA_W          = 7,
  parameter int DEPTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int RDA_MARGIN      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rd_in,
  input  logic                     da_in,
  input  logic                     clr_btn,
  output logic                     rda_out,
  output logic [DATA_W-1:0]        char_data,
  output logic                     char_valid,
  input  logic                     char_ready,
  output logic                     clr_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic {IDLE_LO, IDLE_HI} db_state_t;

  logic [SYNC_STAGES-1:0][DATA_W-1:0] rd_sync;
  logic [SYNC_STAGES-1:0]             da_sync_q, clr_sync_q, vld_pipe;
  logic                               da_sync, da_prev, push, pop, wr_en, full;
  logic [DATA_W-1:0]                  push_data;
  logic [DATA_W-1:0]                  mem [DEPTH];
  logic [PW-1:0]                      wr_ptr, rd_ptr;
  logic [CW-1:0]                      count_next;
  logic                               rda_next;

  // da_prev is held high until the chains refill after reset, so a DA line that
  // is already high when reset releases cannot look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sync    <= '0;
      da_sync_q  <= '0;
      clr_sync_q <= '0;
      vld_pipe   <= '0;
      da_prev    <= 1'b1;
    end else begin
      rd_sync    <= {rd_sync[SYNC_STAGES-2:0], rd_in};
      da_sync_q  <= {da_sync_q[SYNC_STAGES-2:0], da_in};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], clr_btn};
      vld_pipe   <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      da_prev    <= da_sync | ~vld_pipe[SYNC_STAGES-1];
    end
  end

  assign da_sync = da_sync_q[SYNC_STAGES-1];
  assign push    = da_sync & ~da_prev;

  always_comb begin
    push_data = rd_sync[SYNC_STAGES-1];
`ifdef LOWERCASE_FOLD_EN
    if (push_data[6:0] >= 7'h61 && push_data[6:0] <= 7'h7A)
      push_data[6:0] = push_data[6:0] - 7'h20;
`endif
  end

  // FIFO: a full FIFO still accepts a push when a pop frees the head that cycle.
  assign char_valid = (fifo_count != '0);
  assign full       = (fifo_count == CW'(DEPTH));
  assign pop        = char_valid & char_ready;
  assign wr_en      = push & (~full | pop) & ~clr_out;
  assign char_data  = char_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_next = fifo_count;
    if (clr_out)            count_next = '0;
    else if (wr_en && !pop) count_next = fifo_count + CW'(1);
    else if (!wr_en && pop) count_next = fifo_count - CW'(1);
  end
  assign rda_next = (count_next <= CW'(DEPTH - RDA_MARGIN));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_out) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      rda_out    <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (push && full && !pop) overflow <= 1'b1;
      fifo_count <= count_next;
      rda_out    <= rda_next;
    end
  end

  // Clear-button debounce: a level must persist DEBOUNCE_CYCLES before it is taken.
  db_state_t        state, state_nx;
  logic [DBW-1:0]   cnt, cnt_nx;
  logic             clr_lvl, clr_fire;

  assign clr_lvl = clr_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE_LO;
      cnt     <= '0;
      clr_out <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      clr_out <= clr_fire;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    if (clr_lvl != (state == IDLE_HI)) begin
      if (cnt == DBW'(DEBOUNCE_CYCLES - 1))
        state_nx = (state == IDLE_HI) ? IDLE_LO : IDLE_HI;
      else
        cnt_nx = cnt + DBW'(1);
    end
  end

  always_comb clr_fire = (state == IDLE_LO) && (state_nx == IDLE_HI);

endmodule
